// File: rtl/dht11_scheduler.sv
// dht11_scheduler: sequences reads of the DHT11 single-wire reader.
// It issues start pulses periodically (when enable is high) or on demand (medir). It keeps a
// minimum gap between starts and supervises each attempt with a watchdog. A failed attempt is
// retried up to MAX_TENTATIVAS times in total. The last good temperature/humidity pair is held.
//
// Ports:
//   clock, reset            - system clock (rising edge), asynchronous active-low reset
//   enable, medir           - periodic-read enable, one-cycle on-demand request
//   dht_pronto, dht_error   - sticky done / error levels from the reader
//   dht_temperatura/umidade - reader data words
//   dht_start, dht_reset    - one-cycle start pulse, active-high reader reset
//   temperatura, umidade    - last good reading
//   valido, falha           - a read has ever succeeded / last request exhausted its retries
//   nova_medida             - one-cycle pulse when temperatura/umidade update
//   ocupado, db_estado      - busy flag, current state code
module dht11_scheduler #(
    parameter int unsigned PERIOD_CYCLES  = 100_000_000,
    parameter int unsigned MIN_GAP_CYCLES = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
    parameter int unsigned MAX_TENTATIVAS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        medir,
    input  logic        dht_pronto,
    input  logic        dht_error,
    input  logic [15:0] dht_temperatura,
    input  logic [15:0] dht_umidade,
    output logic        dht_start,
    output logic        dht_reset,
    output logic [15:0] temperatura,
    output logic [15:0] umidade,
    output logic        valido,
    output logic        falha,
    output logic        nova_medida,
    output logic        ocupado,
    output logic [3:0]  db_estado
);

    localparam int unsigned GapW = $clog2(MIN_GAP_CYCLES + 1);
    localparam int unsigned PerW = $clog2(PERIOD_CYCLES);
    localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned TenW = $clog2(MAX_TENTATIVAS + 1);

    localparam logic [GapW-1:0] GapMax  = GapW'(MIN_GAP_CYCLES);
    localparam logic [PerW-1:0] PerLast = PerW'(PERIOD_CYCLES - 1);
    localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYCLES - 1);
    localparam logic [TenW-1:0] TenLast = TenW'(MAX_TENTATIVAS - 1);

    typedef enum logic [3:0] {
        StOcioso    = 4'd0,
        StIntervalo = 4'd1,
        StDisparo   = 4'd2,
        StGuarda    = 4'd3,
        StAguarda   = 4'd4,
        StSucesso   = 4'd5,
        StAborta    = 4'd6,
        StRetenta   = 4'd7,
        StFalha     = 4'd8
    } state_e;

    state_e          state_q;
    logic [GapW-1:0] gap_q;
    logic [PerW-1:0] periodo_q;
    logic [WdW-1:0]  watchdog_q;
    logic [TenW-1:0] tentativas_q;
    logic            pendente_q;
    logic            start_q;
    logic            nova_q;
    logic            valido_q;
    logic            falha_q;
    logic [15:0]     temp_q;
    logic [15:0]     umid_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StOcioso;
            gap_q        <= '0;
            periodo_q    <= '0;
            watchdog_q   <= '0;
            tentativas_q <= '0;
            pendente_q   <= 1'b0;
            start_q      <= 1'b0;
            nova_q       <= 1'b0;
            valido_q     <= 1'b0;
            falha_q      <= 1'b0;
            temp_q       <= '0;
            umid_q       <= '0;
        end else begin
            start_q <= 1'b0;
            nova_q  <= 1'b0;

            // Gap restarts at each start and saturates, so an idle scheduler can fire at once.
            if (state_q == StDisparo) begin
                gap_q <= '0;
            end else if (gap_q != GapMax) begin
                gap_q <= gap_q + GapW'(1);
            end

            if (!enable || periodo_q == PerLast) begin
                periodo_q <= '0;
            end else begin
                periodo_q <= periodo_q + PerW'(1);
            end

            // A new request wins over the clear so a request arriving during DISPARO is kept.
            if (medir || (enable && periodo_q == PerLast)) begin
                pendente_q <= 1'b1;
            end else if (state_q == StDisparo && tentativas_q == '0) begin
                pendente_q <= 1'b0;
            end

            if (state_q == StDisparo) begin
                watchdog_q <= '0;
            end else if (state_q == StAguarda) begin
                watchdog_q <= watchdog_q + WdW'(1);
            end

            case (state_q)
                StOcioso: begin
                    if (pendente_q) state_q <= StIntervalo;
                end
                StIntervalo: begin
                    if (gap_q == GapMax) begin
                        state_q <= StDisparo;
                        start_q <= 1'b1;
                    end
                end
                StDisparo: state_q <= StGuarda;
                // Reader drops its stale pronto/error during this cycle; inputs ignored.
                StGuarda:  state_q <= StAguarda;
                StAguarda: begin
                    if (dht_pronto) begin
                        state_q      <= StSucesso;
                        temp_q       <= dht_temperatura;
                        umid_q       <= dht_umidade;
                        valido_q     <= 1'b1;
                        falha_q      <= 1'b0;
                        tentativas_q <= '0;
                        nova_q       <= 1'b1;
                    end else if (dht_error) begin
                        state_q <= StRetenta;
                    end else if (watchdog_q == WdLast) begin
                        state_q <= StAborta;
                    end
                end
                StSucesso: state_q <= StOcioso;
                StAborta:  state_q <= StRetenta;
                StRetenta: begin
                    if (tentativas_q == TenLast) begin
                        state_q      <= StFalha;
                        falha_q      <= 1'b1;
                        tentativas_q <= '0;
                    end else begin
                        state_q      <= StIntervalo;
                        tentativas_q <= tentativas_q + TenW'(1);
                    end
                end
                StFalha:   state_q <= StOcioso;
                default:   state_q <= StOcioso;
            endcase
        end
    end

    assign dht_start   = start_q;
    assign dht_reset   = ~reset | (state_q == StAborta);
    assign temperatura = temp_q;
    assign umidade     = umid_q;
    assign valido      = valido_q;
    assign falha       = falha_q;
    assign nova_medida = nova_q;
    assign ocupado     = (state_q != StOcioso);
    assign db_estado   = state_q;

endmodule

// File: tb/tb_dht11_scheduler.sv
module tb_dht11_scheduler;

    localparam int Per = 200;
    localparam int Gap = 50;
    localparam int To  = 100;
    localparam int RespDly = 10;

    // Reader response modes.
    localparam int MNone = 0;
    localparam int MOk   = 1;
    localparam int MErr  = 2;
    localparam int MBoth = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        medir = 1'b0;
    logic        dht_pronto = 1'b0;
    logic        dht_error = 1'b0;
    logic [15:0] dht_temperatura = '0;
    logic [15:0] dht_umidade = '0;
    logic        dht_start, dht_reset, valido, falha, nova_medida, ocupado;
    logic [15:0] temperatura, umidade;
    logic [3:0]  db_estado;

    dht11_scheduler #(
        .PERIOD_CYCLES (Per),
        .MIN_GAP_CYCLES(Gap),
        .TIMEOUT_CYCLES(To),
        .MAX_TENTATIVAS(3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .medir          (medir),
        .dht_pronto     (dht_pronto),
        .dht_error      (dht_error),
        .dht_temperatura(dht_temperatura),
        .dht_umidade    (dht_umidade),
        .dht_start      (dht_start),
        .dht_reset      (dht_reset),
        .temperatura    (temperatura),
        .umidade        (umidade),
        .valido         (valido),
        .falha          (falha),
        .nova_medida    (nova_medida),
        .ocupado        (ocupado),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          mode;
        logic [15:0] t;
        logic [15:0] h;
    } resp_t;

    typedef struct {
        logic [15:0] t;
        logic [15:0] h;
    } pair_t;

    // Written by the test tasks only.
    resp_t mode_q[$];
    pair_t exp_q[$];
    int    nova_rd = 0;
    int    rel_cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;

    // Written by the cycle counter / monitor / reader model only.
    int    cyc = 0;
    int    start_t[$];
    pair_t nova_log[$];
    int    start_cnt = 0;
    int    rst_cnt = 0;
    int    nova_cnt = 0;
    int    aguarda_run = 0;
    int    last_aguarda = 0;
    int    mode_rd = 0;
    int    rd_cnt = -1;
    resp_t cur;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor plus behavioural reader: start clears the sticky flags two negedges later (so
    // they are still stale while the scheduler is in GUARDA), then it answers per mode_q.
    always @(negedge clock) begin
        if (dht_start) begin
            start_cnt++;
            start_t.push_back(cyc);
            aguarda_run = 0;
        end
        if (dht_reset && reset) rst_cnt++;
        if (nova_medida) begin
            nova_cnt++;
            nova_log.push_back('{temperatura, umidade});
        end
        if (db_estado == 4'd4) begin
            aguarda_run++;
        end else if (db_estado == 4'd6) begin
            last_aguarda = aguarda_run;
            aguarda_run = 0;
        end

        if (dht_reset) begin
            dht_pronto = 1'b0;
            dht_error = 1'b0;
            rd_cnt = -1;
        end else if (dht_start) begin
            rd_cnt = 0;
            if (mode_rd < mode_q.size()) begin
                cur = mode_q[mode_rd];
                mode_rd++;
            end else begin
                cur = '{MNone, 16'h0, 16'h0};
            end
        end else if (rd_cnt >= 0) begin
            rd_cnt++;
            if (rd_cnt == 2) begin
                dht_pronto = 1'b0;
                dht_error = 1'b0;
            end
            if (rd_cnt == 2 + RespDly) begin
                rd_cnt = -1;
                if (cur.mode == MOk || cur.mode == MBoth) begin
                    dht_temperatura = cur.t;
                    dht_umidade = cur.h;
                    dht_pronto = 1'b1;
                end
                if (cur.mode == MErr || cur.mode == MBoth) dht_error = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got cyc=%0d want done", cyc);
        $fatal(1, "global timeout");
    end

    task automatic pulse_medir();
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
    endtask

    task automatic test_reset();
        logic [36:0] v;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        v = {dht_start, valido, falha, nova_medida, ocupado, temperatura, umidade};
        n_tests++;
        if (v !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", v);
        end
        n_tests++;
        if (dht_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_dht_reset: got %b want 1", dht_reset);
        end
        n_tests++;
        if (db_estado !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want 0", db_estado);
        end
        reset = 1'b1;
        rel_cyc = cyc;
        @(negedge clock);
        n_tests++;
        if (dht_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL release_dht_reset: got %b want 0", dht_reset);
        end
    endtask

    task automatic test_single_read();
        int s0, n0;
        pair_t e;
        s0 = start_cnt;
        n0 = nova_cnt;
        repeat (5) @(negedge clock);
        mode_q.push_back('{MOk, 16'h1A00, 16'h3C00});
        exp_q.push_back('{16'h1A00, 16'h3C00});
        pulse_medir();
        for (int i = 0; i < 300 && nova_medida !== 1'b1; i++) @(negedge clock);
        n_tests++;
        if (nova_medida !== 1'b1) begin
            n_fail++;
            $display("FAIL single_wait: got no nova_medida want pulse");
        end
        n_tests++;
        if (db_estado !== 4'd5) begin
            n_fail++;
            $display("FAIL single_state: got %0d want 5", db_estado);
        end
        @(negedge clock);
        n_tests++;
        if (ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ocupado: got %b want 0", ocupado);
        end
        repeat (3) @(negedge clock);
        while (nova_rd < nova_log.size()) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL single_sb: got unexpected %h/%h want none",
                         nova_log[nova_rd].t, nova_log[nova_rd].h);
            end else begin
                e = exp_q.pop_front();
                if (nova_log[nova_rd] != e) begin
                    n_fail++;
                    $display("FAIL single_sb: got %h/%h want %h/%h",
                             nova_log[nova_rd].t, nova_log[nova_rd].h, e.t, e.h);
                end
            end
            nova_rd++;
        end
        n_tests++;
        if (nova_cnt - n0 != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_count: got %0d pulses want 1", nova_cnt - n0);
        end
        n_tests++;
        if (valido !== 1'b1 || falha !== 1'b0) begin
            n_fail++;
            $display("FAIL single_flags: got valido=%b falha=%b want 1/0", valido, falha);
        end
        n_tests++;
        if (start_cnt - s0 != 1 || start_t[s0] - rel_cyc < Gap
            || start_t[s0] - rel_cyc > Gap + 5) begin
            n_fail++;
            $display("FAIL single_start: got %0d starts at offset %0d want 1 at ~%0d",
                     start_cnt - s0, start_t.size() > s0 ? start_t[s0] - rel_cyc : -1, Gap);
        end
    endtask

    task automatic test_timeout();
        int s0, r0, n0;
        s0 = start_cnt;
        r0 = rst_cnt;
        n0 = nova_cnt;
        repeat (3) mode_q.push_back('{MNone, 16'h0, 16'h0});
        pulse_medir();
        for (int i = 0; i < 1000 && falha !== 1'b1; i++) @(negedge clock);
        n_tests++;
        if (falha !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_falha: got %b want 1", falha);
        end
        n_tests++;
        if (db_estado !== 4'd8) begin
            n_fail++;
            $display("FAIL timeout_state: got %0d want 8", db_estado);
        end
        repeat (2) @(negedge clock);
        n_tests++;
        if (valido !== 1'b1 || temperatura !== 16'h1A00 || umidade !== 16'h3C00) begin
            n_fail++;
            $display("FAIL timeout_retain: got %b %h/%h want 1 1a00/3c00",
                     valido, temperatura, umidade);
        end
        n_tests++;
        if (start_cnt - s0 != 3 || rst_cnt - r0 != 3) begin
            n_fail++;
            $display("FAIL timeout_attempts: got starts=%0d resets=%0d want 3/3",
                     start_cnt - s0, rst_cnt - r0);
        end
        n_tests++;
        if (last_aguarda != To) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d want %0d", last_aguarda, To);
        end
        n_tests++;
        if (nova_cnt != n0 || ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_quiet: got nova=%0d ocupado=%b want 0/0",
                     nova_cnt - n0, ocupado);
        end
    endtask

    task automatic test_retry();
        int s0, r0;
        pair_t e;
        s0 = start_cnt;
        r0 = rst_cnt;
        mode_q.push_back('{MErr, 16'h0, 16'h0});
        mode_q.push_back('{MErr, 16'h0, 16'h0});
        mode_q.push_back('{MOk, 16'h1234, 16'h5678});
        exp_q.push_back('{16'h1234, 16'h5678});
        pulse_medir();
        for (int i = 0; i < 600 && nova_medida !== 1'b1; i++) @(negedge clock);
        n_tests++;
        if (nova_medida !== 1'b1) begin
            n_fail++;
            $display("FAIL retry_wait: got no nova_medida want pulse");
        end
        repeat (3) @(negedge clock);
        while (nova_rd < nova_log.size()) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL retry_sb: got unexpected %h/%h want none",
                         nova_log[nova_rd].t, nova_log[nova_rd].h);
            end else begin
                e = exp_q.pop_front();
                if (nova_log[nova_rd] != e) begin
                    n_fail++;
                    $display("FAIL retry_sb: got %h/%h want %h/%h",
                             nova_log[nova_rd].t, nova_log[nova_rd].h, e.t, e.h);
                end
            end
            nova_rd++;
        end
        n_tests++;
        if (start_cnt - s0 != 3 || rst_cnt != r0) begin
            n_fail++;
            $display("FAIL retry_count: got starts=%0d resets=%0d want 3/0",
                     start_cnt - s0, rst_cnt - r0);
        end else begin
            n_tests++;
            if (start_t[s0+1] - start_t[s0] < Gap || start_t[s0+2] - start_t[s0+1] < Gap) begin
                n_fail++;
                $display("FAIL retry_gap: got %0d,%0d want >=%0d",
                         start_t[s0+1] - start_t[s0], start_t[s0+2] - start_t[s0+1], Gap);
            end
        end
        n_tests++;
        if (falha !== 1'b0 || temperatura !== 16'h1234 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL retry_result: got falha=%b temp=%h want 0 1234", falha, temperatura);
        end
    endtask

    task automatic test_periodic();
        int s0, e0, d;
        pair_t e;
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) begin
            mode_q.push_back('{MOk, 16'h2000 + 16'(i), 16'h4000 + 16'(i)});
            exp_q.push_back('{16'h2000 + 16'(i), 16'h4000 + 16'(i)});
        end
        enable = 1'b1;
        e0 = cyc;
        for (int i = 0; i < 800 && start_cnt < s0 + 3; i++) @(negedge clock);
        for (int i = 0; i < 20 && db_estado !== 4'd4; i++) @(negedge clock);
        n_tests++;
        if (db_estado !== 4'd4) begin
            n_fail++;
            $display("FAIL periodic_aguarda: got state %0d want 4", db_estado);
        end
        pulse_medir();
        for (int i = 0; i < 600 && start_cnt < s0 + 5; i++) @(negedge clock);
        enable = 1'b0;
        repeat (450) @(negedge clock);
        n_tests++;
        if (start_cnt - s0 != 5) begin
            n_fail++;
            $display("FAIL periodic_count: got %0d starts want 5", start_cnt - s0);
        end else begin
            n_tests++;
            if (start_t[s0] - e0 != Per + 2) begin
                n_fail++;
                $display("FAIL periodic_first: got %0d want %0d", start_t[s0] - e0, Per + 2);
            end
            n_tests++;
            if (start_t[s0+1] - start_t[s0] != Per || start_t[s0+2] - start_t[s0+1] != Per
                || start_t[s0+4] - start_t[s0+2] != Per) begin
                n_fail++;
                $display("FAIL periodic_spacing: got %0d,%0d,%0d want %0d",
                         start_t[s0+1] - start_t[s0], start_t[s0+2] - start_t[s0+1],
                         start_t[s0+4] - start_t[s0+2], Per);
            end
            d = start_t[s0+3] - start_t[s0+2];
            n_tests++;
            if (d < Gap || d >= Per) begin
                n_fail++;
                $display("FAIL periodic_extra: got %0d want in [%0d,%0d)", d, Gap, Per);
            end
        end
        while (nova_rd < nova_log.size()) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL periodic_sb: got unexpected %h/%h want none",
                         nova_log[nova_rd].t, nova_log[nova_rd].h);
            end else begin
                e = exp_q.pop_front();
                if (nova_log[nova_rd] != e) begin
                    n_fail++;
                    $display("FAIL periodic_sb: got %h/%h want %h/%h",
                             nova_log[nova_rd].t, nova_log[nova_rd].h, e.t, e.h);
                end
            end
            nova_rd++;
        end
        n_tests++;
        if (exp_q.size() != 0 || ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL periodic_drain: got %0d pending ocupado=%b want 0/0",
                     exp_q.size(), ocupado);
        end
    endtask

    task automatic test_both_stale();
        int s0;
        pair_t e;
        s0 = start_cnt;
        mode_q.push_back('{MBoth, 16'hAAAA, 16'h5555});
        exp_q.push_back('{16'hAAAA, 16'h5555});
        pulse_medir();
        for (int i = 0; i < 300 && nova_medida !== 1'b1; i++) @(negedge clock);
        n_tests++;
        if (nova_medida !== 1'b1) begin
            n_fail++;
            $display("FAIL both_wait: got no nova_medida want pulse");
        end
        repeat (RespDly + 5) @(negedge clock);
        while (nova_rd < nova_log.size()) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL both_sb: got unexpected %h/%h want none",
                         nova_log[nova_rd].t, nova_log[nova_rd].h);
            end else begin
                e = exp_q.pop_front();
                if (nova_log[nova_rd] != e) begin
                    n_fail++;
                    $display("FAIL both_sb: got %h/%h want %h/%h",
                             nova_log[nova_rd].t, nova_log[nova_rd].h, e.t, e.h);
                end
            end
            nova_rd++;
        end
        n_tests++;
        if (start_cnt - s0 != 1 || falha !== 1'b0 || temperatura !== 16'hAAAA
            || umidade !== 16'h5555) begin
            n_fail++;
            $display("FAIL both_result: got starts=%0d falha=%b %h/%h want 1 0 aaaa/5555",
                     start_cnt - s0, falha, temperatura, umidade);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        logic [36:0] v;
        pair_t e;
        mode_q.push_back('{MNone, 16'h0, 16'h0});
        pulse_medir();
        for (int i = 0; i < 200 && db_estado !== 4'd4; i++) @(negedge clock);
        repeat (20) @(negedge clock);
        n_tests++;
        if (db_estado !== 4'd4) begin
            n_fail++;
            $display("FAIL mid_state: got %0d want 4", db_estado);
        end
        reset = 1'b0;
        #1;
        v = {dht_start, valido, falha, nova_medida, ocupado, temperatura, umidade};
        n_tests++;
        if (v !== 37'h0 || dht_reset !== 1'b1 || db_estado !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h dht_reset=%b state=%0d want 0 1 0",
                     v, dht_reset, db_estado);
        end
        repeat (3) @(negedge clock);
        n_tests++;
        if (dht_reset !== 1'b1 || valido !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_hold: got dht_reset=%b valido=%b want 1/0", dht_reset, valido);
        end
        reset = 1'b1;
        rel_cyc = cyc;
        s0 = start_cnt;
        mode_q.push_back('{MOk, 16'h0BEE, 16'h0CAF});
        exp_q.push_back('{16'h0BEE, 16'h0CAF});
        @(negedge clock);
        pulse_medir();
        for (int i = 0; i < 300 && nova_medida !== 1'b1; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        while (nova_rd < nova_log.size()) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mid_sb: got unexpected %h/%h want none",
                         nova_log[nova_rd].t, nova_log[nova_rd].h);
            end else begin
                e = exp_q.pop_front();
                if (nova_log[nova_rd] != e) begin
                    n_fail++;
                    $display("FAIL mid_sb: got %h/%h want %h/%h",
                             nova_log[nova_rd].t, nova_log[nova_rd].h, e.t, e.h);
                end
            end
            nova_rd++;
        end
        n_tests++;
        if (start_cnt - s0 != 1 || start_t[s0] - rel_cyc < Gap) begin
            n_fail++;
            $display("FAIL mid_gap: got %0d starts offset %0d want 1 at >=%0d", start_cnt - s0,
                     start_t.size() > s0 ? start_t[s0] - rel_cyc : -1, Gap);
        end
        n_tests++;
        if (valido !== 1'b1 || temperatura !== 16'h0BEE || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_after: got valido=%b temp=%h want 1 0bee", valido, temperatura);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_timeout();
        test_retry();
        test_periodic();
        test_both_stale();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dht11_scheduler.md
# dht11_scheduler

Sequencer for the DHT11 single-wire reader. It issues `start` pulses to the reader, either periodically or on demand, and enforces the sensor's minimum interval between reads. It supervises each transaction with a watchdog, retries failed reads, and holds the last good temperature/humidity pair for the display and serial logic. It sits between the top-level control (buttons, enable switch) and the DHT11 reader instance.

## Interface
Parameters (values for the 50 MHz board clock):
- `PERIOD_CYCLES`, 100_000_000: periodic read interval (2 s).
- `MIN_GAP_CYCLES`, 50_000_000: minimum time between reader `start` pulses (1 s).
- `TIMEOUT_CYCLES`, 1_500_000: watchdog per attempt (30 ms).
- `MAX_TENTATIVAS`, 3: attempts per request, including the first.

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: enables periodic reads.
- `medir` in 1: on-demand read request. Sampled every cycle; a single-cycle pulse is enough.
- `dht_pronto` in 1: reader done level. Sticky; the reader clears it after it accepts `start`.
- `dht_error` in 1: reader error level. Sticky in the same way.
- `dht_temperatura` in 16: reader temperature word.
- `dht_umidade` in 16: reader humidity word.
- `dht_start` out 1: one-cycle start pulse to the reader.
- `dht_reset` out 1: active-high reset to the reader. Equals `~reset | (state==ABORTA)`.
- `temperatura` out 16: last good temperature.
- `umidade` out 16: last good humidity.
- `valido` out 1: high once any read has succeeded.
- `falha` out 1: high when the last request exhausted its retries; cleared on the next success.
- `nova_medida` out 1: one-cycle pulse when `temperatura`/`umidade` update.
- `ocupado` out 1: `state != OCIOSO`.
- `db_estado` out 4: state code.

## Operation

**Reset.** All outputs are 0, except that `dht_reset` is 1 while `reset` is low. State is OCIOSO and all counters are 0, including the gap counter. As a result, the first read after reset waits the full `MIN_GAP_CYCLES`, which covers sensor power-up.

**Counters.**
- `gap`: counts up every cycle and saturates at `MIN_GAP_CYCLES`. It is cleared in DISPARO.
- `periodo`: counts only while `enable` is 1 and is held at 0 otherwise. At `PERIOD_CYCLES-1` it wraps to 0 and sets `pendente`.
- `medir=1`: also sets `pendente`.
- `pendente`: a single flag, so at most one request is queued. It is cleared in DISPARO when `tentativas==0`.
- `watchdog`: cleared in DISPARO and incremented in AGUARDA.
- `tentativas`: width `$clog2(MAX_TENTATIVAS+1)`.

**States** (the code goes to `db_estado`):
- OCIOSO(0): if `pendente`, go to INTERVALO.
- INTERVALO(1): when `gap == MIN_GAP_CYCLES`, go to DISPARO.
- DISPARO(2): `dht_start=1`. Go to GUARDA.
- GUARDA(3): one cycle. The reader clears its stale `pronto`/`error` during this cycle; the inputs are ignored. Go to AGUARDA.
- AGUARDA(4), checked in priority order:
  1. `dht_pronto` goes to SUCESSO.
  2. Otherwise `dht_error` goes to RETENTA.
  3. Otherwise `watchdog == TIMEOUT_CYCLES-1` goes to ABORTA.
- SUCESSO(5): latch `dht_temperatura`/`dht_umidade`. Set `valido=1`, `falha=0`, `tentativas=0`, and pulse `nova_medida`. Go to OCIOSO.
- ABORTA(6): `dht_reset=1` for one cycle. Go to RETENTA.
- RETENTA(7): if `tentativas+1 == MAX_TENTATIVAS`, go to FALHA. Otherwise increment `tentativas` and go to INTERVALO, so the gap is honoured before the retry.
- FALHA(8): set `falha=1`, `tentativas=0`. `valido`, `temperatura` and `umidade` are retained. No `nova_medida` pulse. Go to OCIOSO.
- Codes 9–15: go to OCIOSO.

**Boundary conditions.**
- `pronto` and `error` high in the same cycle: success.
- `pronto` high in the watchdog's final cycle: success.
- `medir` or a period wrap while busy: sets `pendente`, which is served after return to OCIOSO, still subject to the gap.
- `enable` falling mid-transaction: the transaction completes.
- `reset` asserted in any state: immediate return to the reset values; the reader is held in reset.

## Timing
- All outputs are registered, except `dht_reset`, `ocupado` and `db_estado`, which decode state.
- `pendente` seen in OCIOSO with the gap saturated: `dht_start` rises 2 cycles later.
- `dht_pronto` first sampled high in AGUARDA: outputs update and `nova_medida` pulses on the next edge. `ocupado` drops one cycle after that.
- Consecutive `dht_start` pulses are always at least `MIN_GAP_CYCLES` cycles apart, rising edge to rising edge.
- A timed-out attempt lasts `TIMEOUT_CYCLES` cycles in AGUARDA, then 1 cycle of ABORTA.

## Test plan
Use parameters PERIOD=200, MIN_GAP=50, TIMEOUT=100, MAX=3, with a behavioural reader model.
1. Release reset, pulse `medir` at cycle 5. Expect `dht_start` at cycle ≥50. The model returns `pronto` with temperatura=16'h1A00 and umidade=16'h3C00. Expect both outputs latched, `valido=1`, and exactly one `nova_medida` pulse.
2. The model returns `error` twice, then succeeds. Expect 3 `dht_start` pulses spaced ≥50 cycles apart, `falha=0`, and the data updated.
3. After scenario 1, the model never responds. Expect each attempt to time out after 100 cycles, 3 `dht_reset` pulses, then `falha=1` with `valido=1`, 16'h1A00 and 16'h3C00 retained.
4. `enable=1` with no `medir`. Expect `dht_start` every 200 cycles. A `medir` pulse during AGUARDA causes exactly one extra read, started no earlier than 50 cycles after the previous start.
5. `pronto` and `error` asserted together: expect success. A stale `pronto` still high from the prior read during GUARDA must not produce an early success.
6. Drive `reset` low mid-AGUARDA. Expect all outputs 0 and `dht_reset=1` while low. After release, the next `dht_start` comes no earlier than 50 cycles later.
